// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmitter.
package uart_pkg;

    localparam int   UART_CLOCK_DEFAULT = 434;  // 50 MHz / 115.2 kbaud
    localparam int   DATA_BITS          = 8;
    localparam logic IDLE_LEVEL         = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous show-ahead FIFO feeding the UART transmitter.
// rd_data presents the oldest entry combinationally whenever !empty.
module uart_tx_fifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array: written only on an accepted push, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line.
// Latency: with the block idle and the FIFO empty, a byte accepted at edge N
// is popped at edge N+1 and tx is driven low by that same edge (tx=0 after N+1).
// Back-to-back frames are chained from the last STOP cycle with no idle gap.
// UART_CLOCK must be at least 2.
module uart_tx
    import uart_pkg::*;
#(
    parameter int UART_CLOCK = UART_CLOCK_DEFAULT,
    parameter int FIFO_AW    = 2
) (
    input  logic                 clock_50M,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count
);

    localparam int               CNT_W    = (UART_CLOCK > 1) ? $clog2(UART_CLOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_CLOCK - 1);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;

    logic                 w_bit_last;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic [FIFO_AW:0]     w_count;

    assign w_bit_last = (r_cnt == CNT_LAST);
    // A new frame is fetched only from IDLE or at the very end of a stop bit.
    assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_last));

    uart_tx_fifo #(
        .AW (FIFO_AW),
        .DW (DATA_BITS)
    ) u_fifo (
        .clk     (clock_50M),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Frame sequencing, bit timing and the registered serial line.
    always_ff @(posedge clock_50M) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= IDLE_LEVEL;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx  <= IDLE_LEVEL;
                    r_cnt <= '0;
                    if (w_pop) begin
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_last) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_last) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_tx    <= IDLE_LEVEL;
                            r_state <= STOP;
                        end else begin
                            r_tx  <= r_shift[1];
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_last) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Shift register: loaded on pop, advanced at each data-bit boundary so bit 0 is next.
    always_ff @(posedge clock_50M) begin
        if (w_pop) begin
            r_shift <= w_fifo_data;
        end else if ((r_state == DATA) && w_bit_last) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign tx         = r_tx;
    assign tx_ready   = !w_full;
    assign fifo_count = w_count;
    assign busy       = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: one instance at UART_CLOCK=4 for the functional
// scenarios and one at the default 434 for full-rate frame timing.
// A scoreboard queue holds expected frames; a monitor decodes tx and compares.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance (UART_CLOCK = 4)
    logic       a_rst, a_valid, a_ready, a_tx, a_busy;
    logic [7:0] a_data;
    logic [2:0] a_count;

    // Default-rate instance (UART_CLOCK = 434)
    logic       b_rst, b_valid, b_ready, b_tx, b_busy;
    logic [7:0] b_data;
    logic [2:0] b_count;

    uart_tx #(.UART_CLOCK(4), .FIFO_AW(2)) dut_a (
        .clock_50M  (clk),
        .rst        (a_rst),
        .tx_data    (a_data),
        .tx_valid   (a_valid),
        .tx_ready   (a_ready),
        .tx         (a_tx),
        .busy       (a_busy),
        .fifo_count (a_count)
    );

    uart_tx #(.UART_CLOCK(434), .FIFO_AW(2)) dut_b (
        .clock_50M  (clk),
        .rst        (b_rst),
        .tx_data    (b_data),
        .tx_valid   (b_valid),
        .tx_ready   (b_ready),
        .tx         (b_tx),
        .busy       (b_busy),
        .fifo_count (b_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         gap;   // expected idle cycles before the frame, -1 = don't care
    } exp_t;
    exp_t sb_q[$];

    // Monitor looks at whichever instance is selected
    logic sel = 1'b0;
    logic m_tx, m_rst;
    int   m_uc;
    assign m_tx  = sel ? b_tx  : a_tx;
    assign m_rst = sel ? b_rst : a_rst;
    assign m_uc  = sel ? 434 : 4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [7:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle_a(input int maxc);
        int k = 0;
        while (a_busy !== 1'b0 && k < maxc) begin
            tick();
            k++;
        end
        chk("idle_timeout", {31'b0, a_busy}, 32'd0);
    endtask

    // Frame monitor: samples every cycle of every bit, so a bit of the wrong
    // length shows up as an unstable bit or a wrong value.
    initial begin : monitor
        int         gap;
        logic [9:0] bits;
        logic       stable;
        logic       abort;
        exp_t       e;
        gap = 0;
        forever begin
            @(negedge clk);
            if (m_rst === 1'b1) begin
                gap = 0;
            end else if (m_tx === 1'b0) begin
                bits   = '0;
                stable = 1'b1;
                abort  = 1'b0;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int c = 0; c < m_uc; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (m_rst === 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = m_tx;
                        else if (m_tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (!abort) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %02h, required no frame", bits[8:1]);
                    end else begin
                        e = sb_q.pop_front();
                        chk("frame_start", {31'b0, bits[0]}, 32'd0);
                        chk("frame_stop", {31'b0, bits[9]}, 32'd1);
                        chk("frame_bit_stable", {31'b0, stable}, 32'd1);
                        chk("frame_data", {24'b0, bits[8:1]}, {24'b0, e.data});
                        if (e.gap >= 0) chk("frame_gap", gap, e.gap);
                    end
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin : stimulus
        a_rst = 1'b1; a_valid = 1'b0; a_data = 8'h00;
        b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_tx", {31'b0, a_tx}, 32'd1);
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_count", {29'b0, a_count}, 32'd0);
        chk("rst_ready", {31'b0, a_ready}, 32'd1);
        chk("rst_tx_b", {31'b0, b_tx}, 32'd1);
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) tick();

        // Single byte 0x55: tx low after N+1, frame 40 cycles, idle at N+41
        a_valid = 1'b1; a_data = 8'h55; sb_push(8'h55, -1);
        tick();                                     // edge N
        a_valid = 1'b0;
        chk("single_cnt_N", {29'b0, a_count}, 32'd1);
        chk("single_tx_N", {31'b0, a_tx}, 32'd1);
        chk("single_busy_N", {31'b0, a_busy}, 32'd1);
        tick();                                     // edge N+1
        chk("single_tx_N1", {31'b0, a_tx}, 32'd0);
        chk("single_cnt_N1", {29'b0, a_count}, 32'd0);
        repeat (39) tick();                         // edge N+40
        chk("single_busy_N40", {31'b0, a_busy}, 32'd1);
        chk("single_tx_stop", {31'b0, a_tx}, 32'd1);
        tick();                                     // edge N+41
        chk("single_busy_end", {31'b0, a_busy}, 32'd0);
        chk("single_tx_end", {31'b0, a_tx}, 32'd1);
        repeat (3) tick();

        // Back-to-back 0x00, 0xFF, 0xA5 pushed on consecutive edges
        a_valid = 1'b1; a_data = 8'h00; sb_push(8'h00, -1);
        tick();                                     // M
        chk("b2b_cnt_M", {29'b0, a_count}, 32'd1);
        a_data = 8'hFF; sb_push(8'hFF, 0);
        tick();                                     // M+1: push and pop together
        chk("b2b_cnt_M1", {29'b0, a_count}, 32'd1);
        a_data = 8'hA5; sb_push(8'hA5, 0);
        tick();                                     // M+2
        chk("b2b_cnt_M2", {29'b0, a_count}, 32'd2);
        a_valid = 1'b0; a_data = 8'h99;
        repeat (38) begin tick(); chk("b2b_busy", {31'b0, a_busy}, 32'd1); end   // M+40
        chk("b2b_cnt_M40", {29'b0, a_count}, 32'd2);
        tick();                                     // M+41
        chk("b2b_cnt_M41", {29'b0, a_count}, 32'd1);
        chk("b2b_tx_M41", {31'b0, a_tx}, 32'd0);
        repeat (39) begin tick(); chk("b2b_busy", {31'b0, a_busy}, 32'd1); end   // M+80
        tick();                                     // M+81
        chk("b2b_cnt_M81", {29'b0, a_count}, 32'd0);
        repeat (39) begin tick(); chk("b2b_busy", {31'b0, a_busy}, 32'd1); end   // M+120
        tick();                                     // M+121
        chk("b2b_busy_end", {31'b0, a_busy}, 32'd0);
        repeat (3) tick();

        // Full FIFO: 0x10 shifting, 0x11..0x14 fill it, 0x15 refused
        a_valid = 1'b1; a_data = 8'h10; sb_push(8'h10, -1);
        tick();                                     // P
        a_valid = 1'b0;
        tick();                                     // P+1
        chk("full_cnt_P1", {29'b0, a_count}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_data = 8'h10 + 8'(i); sb_push(8'h10 + 8'(i), 0);
            tick();                                 // P+2 .. P+5
        end
        chk("full_cnt_P5", {29'b0, a_count}, 32'd4);
        chk("full_ready_P5", {31'b0, a_ready}, 32'd0);
        a_data = 8'h15;
        repeat (35) tick();                         // P+40
        chk("full_cnt_P40", {29'b0, a_count}, 32'd4);
        chk("full_ready_P40", {31'b0, a_ready}, 32'd0);
        tick();                                     // P+41: pop, 0x15 refused
        a_valid = 1'b0;
        chk("full_cnt_P41", {29'b0, a_count}, 32'd3);
        chk("full_ready_P41", {31'b0, a_ready}, 32'd1);
        repeat (39) tick();                         // P+80
        a_valid = 1'b1; a_data = 8'h16; sb_push(8'h16, 0);
        tick();                                     // P+81: push and pop together
        a_valid = 1'b0;
        chk("pushpop_cnt", {29'b0, a_count}, 32'd3);
        wait_idle_a(400);
        repeat (3) tick();

        // Reset during data bit 3 of 0x3C with two bytes queued
        a_valid = 1'b1; a_data = 8'h3C;
        tick();                                     // R
        a_data = 8'h77;
        tick();                                     // R+1
        a_data = 8'h88;
        tick();                                     // R+2
        a_valid = 1'b0;
        chk("rstmid_cnt", {29'b0, a_count}, 32'd2);
        repeat (16) tick();                         // R+18, inside bit 3
        a_rst = 1'b1;
        tick();                                     // R+19
        chk("rstmid_tx", {31'b0, a_tx}, 32'd1);
        chk("rstmid_cnt0", {29'b0, a_count}, 32'd0);
        chk("rstmid_busy", {31'b0, a_busy}, 32'd0);
        chk("rstmid_ready", {31'b0, a_ready}, 32'd1);
        a_rst = 1'b0;
        repeat (100) tick();
        chk("rstmid_tx_quiet", {31'b0, a_tx}, 32'd1);
        chk("rstmid_busy_quiet", {31'b0, a_busy}, 32'd0);

        // Default rate: one 0xC3 frame of 4340 cycles
        sel = 1'b1;
        tick();
        b_valid = 1'b1; b_data = 8'hC3; sb_push(8'hC3, -1);
        tick();                                     // N
        b_valid = 1'b0;
        chk("slow_tx_N", {31'b0, b_tx}, 32'd1);
        tick();                                     // N+1
        chk("slow_tx_N1", {31'b0, b_tx}, 32'd0);
        repeat (4339) tick();                       // N+4340
        chk("slow_busy_N4340", {31'b0, b_busy}, 32'd1);
        tick();                                     // N+4341
        chk("slow_busy_end", {31'b0, b_busy}, 32'd0);
        chk("slow_tx_end", {31'b0, b_tx}, 32'd1);
        repeat (5) tick();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
